// File: rtl/timer_pkg.sv
// timer_pkg: shared timer state encoding and reset state
package timer_pkg;
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} timer_state_t;
  localparam timer_state_t STATE_RST = T_IDLE;
endpackage

// File: rtl/adder.sv
// adder: WIDTH-bit combinational adder, carry out discarded
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter, load/done valid-ready handshake with pause and abort
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_sH,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready
);
  timer_state_t state;
  logic [WIDTH-1:0] dec;
  adder #(.WIDTH(WIDTH)) u_dec (.a(count), .b({WIDTH{1'b1}}), .sum(dec));
  assign load_ready = state == T_IDLE;
  assign busy       = state == T_RUN;
  assign done_valid = state == T_DONE;
  always_ff @(posedge clk) begin
    if (rst_sH) begin
      state <= STATE_RST;
      count <= '0;
    end else begin
      case (state)
        T_IDLE: if (load_valid) begin
          count <= load_value;
          state <= load_value != '0 ? T_RUN : T_DONE;
        end
        T_RUN: if (abort) begin
          count <= '0;
          state <= T_IDLE;
        end else if (!pause) begin
          count <= dec;
          if (dec == '0) state <= T_DONE;
        end
        T_DONE: if (done_ready || abort) state <= T_IDLE;
        default: state <= T_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer at WIDTH 8 and WIDTH 4
module tb_countdown_timer;
  localparam logic [2:0] IDLE = 3'b100, RUN = 3'b010, DONE = 3'b001;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, lv = 0, pause = 0, abort = 0, dr = 0;
  logic [7:0] val = 0;
  logic lr, bz, dv;
  logic [7:0] cnt;
  logic rst4 = 1, lv4 = 0, dr4 = 0;
  logic [3:0] val4 = 0;
  logic lr4, bz4, dv4;
  logic [3:0] cnt4;
  logic [10:0] obs, obs4, x;
  logic [10:0] q[$];
  int tests = 0, fails = 0;
  assign obs  = {cnt, lr, bz, dv};
  assign obs4 = {4'b0, cnt4, lr4, bz4, dv4};
  countdown_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst_sH(rst), .load_valid(lv), .load_ready(lr), .load_value(val),
    .pause(pause), .abort(abort), .count(cnt), .busy(bz), .done_valid(dv), .done_ready(dr)
  );
  countdown_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_sH(rst4), .load_valid(lv4), .load_ready(lr4), .load_value(val4),
    .pause(1'b0), .abort(1'b0), .count(cnt4), .busy(bz4), .done_valid(dv4), .done_ready(dr4)
  );
  function automatic logic [10:0] e(input int c, input logic [2:0] f);
    logic [7:0] c8;
    c8 = c[7:0];
    return {c8, f};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1; lv = 1; val = 8'd9; dr = 0;
    for (int i = 0; i < 3; i++) begin
      q.push_back(e(0, IDLE));
      tick;
      tests++; x = q.pop_front();
      if (obs !== x) begin fails++; $display("FAIL reset[%0d]: got %h want %h", i, obs, x); end
    end
    rst = 0; lv = 0;
  endtask
  task automatic test_load5;
    lv = 1; val = 8'd5; dr = 1; abort = 1;
    q.push_back(e(5, RUN));
    tick;
    tests++; x = q.pop_front();
    if (obs !== x) begin fails++; $display("FAIL load5_accept: got %h want %h", obs, x); end
    lv = 0; abort = 0;
    for (int i = 1; i <= 6; i++) begin
      q.push_back(i < 5 ? e(5 - i, RUN) : i == 5 ? e(0, DONE) : e(0, IDLE));
      tick;
      tests++; x = q.pop_front();
      if (obs !== x) begin fails++; $display("FAIL load5[%0d]: got %h want %h", i, obs, x); end
    end
    dr = 0;
  endtask
  task automatic test_load0;
    lv = 1; val = 8'd0; dr = 0;
    q.push_back(e(0, DONE));
    tick;
    tests++; x = q.pop_front();
    if (obs !== x) begin fails++; $display("FAIL load0_done: got %h want %h", obs, x); end
    val = 8'd7;
    for (int i = 0; i < 4; i++) begin
      q.push_back(e(0, DONE));
      tick;
      tests++; x = q.pop_front();
      if (obs !== x) begin fails++; $display("FAIL load0_hold[%0d]: got %h want %h", i, obs, x); end
    end
    lv = 0; dr = 1;
    for (int i = 0; i < 2; i++) begin
      q.push_back(e(0, IDLE));
      tick;
      tests++; x = q.pop_front();
      if (obs !== x) begin fails++; $display("FAIL load0_release[%0d]: got %h want %h", i, obs, x); end
    end
  endtask
  task automatic test_pause;
    logic [5:0] p;
    p = 6'b000110;
    lv = 1; val = 8'd3; dr = 1;
    q.push_back(e(3, RUN));
    tick;
    tests++; x = q.pop_front();
    if (obs !== x) begin fails++; $display("FAIL pause_accept: got %h want %h", obs, x); end
    lv = 0;
    for (int i = 1; i <= 6; i++) begin
      pause = p[i-1];
      q.push_back(i <= 3 ? e(2, RUN) : i == 4 ? e(1, RUN) : i == 5 ? e(0, DONE) : e(0, IDLE));
      tick;
      tests++; x = q.pop_front();
      if (obs !== x) begin fails++; $display("FAIL pause[%0d]: got %h want %h", i, obs, x); end
    end
    pause = 0;
  endtask
  task automatic test_abort;
    lv = 1; val = 8'd200; dr = 1;
    q.push_back(e(200, RUN));
    tick;
    tests++; x = q.pop_front();
    if (obs !== x) begin fails++; $display("FAIL abort_accept: got %h want %h", obs, x); end
    lv = 0;
    for (int i = 1; i <= 50; i++) begin
      q.push_back(e(200 - i, RUN));
      tick;
      tests++; x = q.pop_front();
      if (obs !== x) begin fails++; $display("FAIL abort_run[%0d]: got %h want %h", i, obs, x); end
    end
    pause = 1; abort = 1;
    q.push_back(e(0, IDLE));
    tick;
    tests++; x = q.pop_front();
    if (obs !== x) begin fails++; $display("FAIL abort_hit: got %h want %h", obs, x); end
    pause = 0; abort = 0;
    for (int i = 0; i < 3; i++) begin
      q.push_back(e(0, IDLE));
      tick;
      tests++; x = q.pop_front();
      if (obs !== x) begin fails++; $display("FAIL abort_after[%0d]: got %h want %h", i, obs, x); end
    end
  endtask
  task automatic test_width4;
    rst4 = 0; lv4 = 1; val4 = 4'd15; dr4 = 0;
    q.push_back(e(15, RUN));
    tick;
    tests++; x = q.pop_front();
    if (obs4 !== x) begin fails++; $display("FAIL w4_accept: got %h want %h", obs4, x); end
    lv4 = 0;
    for (int i = 1; i <= 17; i++) begin
      dr4 = i == 17;
      q.push_back(i < 15 ? e(15 - i, RUN) : i < 17 ? e(0, DONE) : e(0, IDLE));
      tick;
      tests++; x = q.pop_front();
      if (obs4 !== x) begin fails++; $display("FAIL w4_run[%0d]: got %h want %h", i, obs4, x); end
    end
    dr4 = 0; lv4 = 1;
    for (int i = 0; i < 3; i++) begin
      q.push_back(e(15 - i, RUN));
      tick;
      lv4 = 0;
      tests++; x = q.pop_front();
      if (obs4 !== x) begin fails++; $display("FAIL w4_reload[%0d]: got %h want %h", i, obs4, x); end
    end
    rst4 = 1;
    q.push_back(e(0, IDLE));
    tick;
    tests++; x = q.pop_front();
    if (obs4 !== x) begin fails++; $display("FAIL w4_reset: got %h want %h", obs4, x); end
    rst4 = 0;
  endtask
  initial begin
    test_reset;
    test_load5;
    test_load0;
    test_pause;
    test_abort;
    test_width4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
